// File: rtl/apb_regs_pkg.sv
// Shared types for the APB register file: access modes, decode rules and
// the APB4 request/response structs used by default.
package apb_regs_pkg;

  typedef enum logic [1:0] {
    REG_RW   = 2'd0,
    REG_RO   = 2'd1,
    REG_W1C  = 2'd2,
    REG_HWRO = 2'd3
  } reg_mode_e;

  localparam int unsigned MaxWaitCycles = 15;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } rule_t;

  typedef struct packed {
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;

endpackage

// File: rtl/apb_regs_hw_wait_ctrl.sv
// Access-phase wait counter: holds pready low for WaitCycles cycles and
// flags the single cycle on which the transfer commits.
module apb_wait_ctrl
  import apb_regs_pkg::*;
#(
  parameter int unsigned WaitCycles = 0
) (
  input  logic pclk_i,
  input  logic preset_ni,
  input  logic psel,
  input  logic penable,
  output logic pready_o,
  output logic commit_o
);
  localparam int unsigned CntW = $clog2(MaxWaitCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            access;

  assign access   = psel & penable;
  assign pready_o = access & (cnt_q == CntW'(WaitCycles));
  assign commit_o = pready_o;

  // Any gap in psel/penable, or completion, restarts the count.
  always_comb begin
    cnt_d = '0;
    if (access && !pready_o) cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/apb_regs_hw.sv
// APB4 register file with per-register access modes (RW/RO/W1C/HWRO), a
// hardware update port, wait states, write strobes and a W1C interrupt.
module apb_regs_hw
  import apb_regs_pkg::*;
#(
  parameter int unsigned NoApbRegs    = 4,
  parameter int unsigned ApbAddrWidth = 12,
  parameter int unsigned AddrOffset   = 4,
  parameter int unsigned ApbDataWidth = 32,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned WaitCycles   = 0,
  parameter reg_mode_e [NoApbRegs-1:0] RegMode = {NoApbRegs{REG_RW}},
  parameter type req_t  = apb_req_t,
  parameter type resp_t = apb_resp_t
) (
  input  logic                                   pclk_i,
  input  logic                                   preset_ni,
  input  req_t                                   req_i,
  output resp_t                                  resp_o,
  input  logic [ApbAddrWidth-1:0]                base_addr_i,
  input  logic [NoApbRegs-1:0][RegDataWidth-1:0] reg_init_i,
  input  logic [NoApbRegs-1:0]                   hw_we_i,
  input  logic [NoApbRegs-1:0][RegDataWidth-1:0] hw_d_i,
  output logic [NoApbRegs-1:0][RegDataWidth-1:0] reg_q_o,
  output logic [NoApbRegs-1:0]                   reg_wr_o,
  output logic                                   irq_o
);
  localparam int unsigned StrbWidth = (ApbDataWidth + 7) / 8;

  logic [NoApbRegs-1:0][RegDataWidth-1:0] reg_q, reg_d;
  logic [NoApbRegs-1:0]                   reg_wr_q, reg_wr_d;
  logic                                   has_reset_q, has_reset_d;
  rule_t [NoApbRegs-1:0]                  rules;
  logic [NoApbRegs-1:0]                   hit, sw_wr;
  logic                                   dec_hit, pready, commit, wr_err, strb_any;
  logic [RegDataWidth-1:0]                wmask, wdata, rd_val;
  logic                                   unused_sig;

  // The first edge after reset is spent loading init values, so no access
  // may start in that cycle.
  apb_wait_ctrl #(
    .WaitCycles(WaitCycles)
  ) u_wait_ctrl (
    .pclk_i   (pclk_i),
    .preset_ni(preset_ni),
    .psel     (req_i.psel & has_reset_q),
    .penable  (req_i.penable),
    .pready_o (pready),
    .commit_o (commit)
  );

  always_comb begin
    hit = '0;
    for (int i = 0; i < NoApbRegs; i++) begin
      rules[i].idx        = 32'(i);
      rules[i].start_addr = 32'(base_addr_i) + 32'(i * AddrOffset);
      rules[i].end_addr   = 32'(base_addr_i) + 32'((i + 1) * AddrOffset);
      hit[i] = (32'(req_i.paddr[ApbAddrWidth-1:0]) >= rules[i].start_addr) &&
               (32'(req_i.paddr[ApbAddrWidth-1:0]) <  rules[i].end_addr);
    end
  end

  assign dec_hit  = |hit;
  assign wdata    = req_i.pwdata[RegDataWidth-1:0];
  assign strb_any = |req_i.pstrb[StrbWidth-1:0];

  always_comb begin
    wmask = '0;
    for (int b = 0; b < RegDataWidth; b++) wmask[b] = req_i.pstrb[b/8];
  end

  always_comb begin
    wr_err = 1'b0;
    rd_val = '0;
    sw_wr  = '0;
    for (int i = 0; i < NoApbRegs; i++) begin
      if (hit[i]) begin
        rd_val = (RegMode[i] == REG_RO) ? reg_init_i[i] : reg_q[i];
        wr_err = RegMode[i] inside {REG_RO, REG_HWRO};
      end
      sw_wr[i] = commit & req_i.pwrite & hit[i] & strb_any &
                 (RegMode[i] inside {REG_RW, REG_W1C});
    end
  end

  // W1C: a hardware set in the same cycle as a software clear wins.
  always_comb begin
    reg_d       = reg_q;
    reg_wr_d    = sw_wr;
    has_reset_d = 1'b1;
    for (int i = 0; i < NoApbRegs; i++) begin
      if (!has_reset_q) begin
        if (RegMode[i] != REG_RO) reg_d[i] = reg_init_i[i];
      end else begin
        case (RegMode[i])
          REG_RW: begin
            if (sw_wr[i])        reg_d[i] = (reg_q[i] & ~wmask) | (wdata & wmask);
            else if (hw_we_i[i]) reg_d[i] = hw_d_i[i];
          end
          REG_W1C: reg_d[i] = (reg_q[i] & ~({RegDataWidth{sw_wr[i]}} & wdata & wmask)) |
                              ({RegDataWidth{hw_we_i[i]}} & hw_d_i[i]);
          REG_HWRO: if (hw_we_i[i]) reg_d[i] = hw_d_i[i];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      reg_q       <= '0;
      reg_wr_q    <= '0;
      has_reset_q <= 1'b0;
    end else begin
      reg_q       <= reg_d;
      reg_wr_q    <= reg_wr_d;
      has_reset_q <= has_reset_d;
    end
  end

  always_comb begin
    resp_o         = '0;
    resp_o.pready  = pready;
    resp_o.pslverr = pready & (~dec_hit | (req_i.pwrite & wr_err));
    if (pready && dec_hit && !req_i.pwrite)
      resp_o.prdata[ApbDataWidth-1:0] = ApbDataWidth'(rd_val);
  end

  always_comb begin
    reg_q_o = reg_q;
    irq_o   = 1'b0;
    for (int i = 0; i < NoApbRegs; i++) begin
      if (RegMode[i] == REG_RO)  reg_q_o[i] = reg_init_i[i];
      if (RegMode[i] == REG_W1C) irq_o = irq_o | (|reg_q[i]);
    end
  end

  assign reg_wr_o   = reg_wr_q;
  assign unused_sig = ^{req_i, rules, hw_we_i, hw_d_i};

endmodule
